ddr3_rd_data_checker: RTL and testbench
=======================================

Name: ddr3_rd_data_checker

Overview:
- Downstream consumer of the 128-bit LFSR pattern generator in the DDR3 error-detection path.
- Compares each DDR3 read-data beat against the expected pattern (the generator's q) and steps the generator once per accepted beat.
- Counts mismatching beats, accumulates a sticky per-bit error mask, captures the first failing beat, and reports done/pass to the test controller.

Parameters:
- DW, 128, data and pattern width; must equal the generator width.
- BEATS_W, 16, width of the beat-count request and beat counter.
- ERRCNT_W, 32, width of the saturating error-beat counter.

Ports:
- clk  in  1  single clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a check run. Honoured only in IDLE or DONE.
- abort  in  1  one-cycle pulse; returns the block to IDLE from any state.
- num_beats  in  BEATS_W  beats to check. Sampled on start.
- rd_valid  in  1  rd_data holds a valid read beat this cycle.
- rd_data  in  DW  read data from the DDR3 controller.
- exp_data  in  DW  expected pattern; connects to the generator's q.
- lfsr_clear  out  1  reseeds the generator. Connects to its clear input.
- lfsr_enable  out  1  advances the generator. Connects to its enable input.
- busy  out  1  high in SEED, RUN and FLUSH.
- done  out  1  high while in DONE.
- pass  out  1  done and err_cnt==0.
- err_cnt  out  ERRCNT_W  mismatching beats; saturates at all-ones.
- err_bits  out  DW  sticky OR of all per-beat XOR differences.
- first_err_beat  out  BEATS_W  index of the first mismatching beat.
- first_err_data  out  DW  rd_data of the first mismatching beat.
- beat_cnt  out  BEATS_W  beats accepted in the current run.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE.
  - All outputs 0; pipeline valid flag 0.
  - lfsr_clear=0 and lfsr_enable=0 during reset.
- IDLE or DONE, start=1:
  - Go to SEED.
  - Latch num_beats into num_q.
- SEED (one cycle):
  - lfsr_clear=1.
  - Clear err_cnt, err_bits, first_err_*, beat_cnt and the internal first-error flag.
  - Next state is RUN, or DONE directly if num_q==0 (then pass=1).
- RUN:
  - lfsr_enable = rd_valid, combinational and registered nowhere. The generator steps on the same edge that accepts the beat, so exp_data always matches the next beat.
  - On an accepted beat, stage 1 registers diff_q = rd_data ^ exp_data, plus diff_v=1, data_q, and idx_q=beat_cnt; beat_cnt increments.
  - Gaps (rd_valid=0) do not advance the generator or the counters.
  - When the beat with beat_cnt==num_q-1 is accepted, go to FLUSH.
- FLUSH (one cycle): stage 2 absorbs the final diff, then go to DONE.
- Stage 2 (every cycle with diff_v=1 and diff_q!=0):
  - err_cnt += 1, saturating; it stays at all-ones.
  - err_bits |= diff_q.
  - If the first-error flag is clear: first_err_beat=idx_q, first_err_data=data_q, set the flag.
- Latency:
  - A beat appears in err_cnt and err_bits 2 clk after acceptance.
  - done rises 2 clk after the final beat is accepted.
- DONE:
  - Results held.
  - rd_valid is ignored; lfsr_enable=0.
  - start launches a new run.
- Boundary cases:
  - start outside IDLE/DONE: ignored.
  - abort in any state: next state IDLE, lfsr_enable=0 that cycle, diff_v cleared, results held (not cleared). abort has priority over start in the same cycle.
  - rd_valid outside RUN: ignored; no generator step.
  - beat_cnt does not wrap; the run ends at num_q. num_q max = 2^BEATS_W-1.
  - Synchronous reset mid-run: immediate IDLE, all outputs cleared.

Decomposition:
- Shared package ddr3_chk_pkg holds:
  - state enum: IDLE, SEED, RUN, FLUSH, DONE;
  - DW default;
  - seed constant 128'h0123456789abcdeffedcba9876543210, for benches.
- The generator is instantiated at the parent level, not inside this block.
- One natural sub-module: ddr3_chk_accum, the stage-2 error counter, sticky mask and first-error capture.

Test Plan:
- Clean run: num_beats=4; feed 4 back-to-back beats equal to the generator sequence from seed → done 2 clk after beat 3, pass=1, err_cnt=0, err_bits=0, lfsr_enable high exactly 4 cycles.
- Single-bit error: num_beats=8; flip bit 5 of beat 2 → err_cnt=1, err_bits=128'h20, first_err_beat=2, first_err_data=golden^128'h20, pass=0.
- Gapped valid: num_beats=6; rd_valid pattern 1,0,0,1,1,0,1,1,1 with golden data → pass=1, lfsr_enable high exactly 6 cycles, beat_cnt=6.
- Saturation: ERRCNT_W=4; num_beats=20, all beats corrupted → err_cnt=15, first_err_beat=0.
- Abort and restart: abort after 3 of 10 beats → IDLE, busy=0, results held; then start with num_beats=2 → lfsr_clear pulses one cycle, pass=1.
- Zero length, and reset mid-run: num_beats=0 → SEED then DONE, pass=1, lfsr_enable never asserted; resetn=0 during RUN → next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/ddr3_chk_pkg.sv
// Shared definitions for the DDR3 read-data checker: FSM state encoding,
// default data width and the pattern-generator seed used by benches.
package ddr3_chk_pkg;

    localparam int DW_DEF = 128;

    // Value the pattern generator loads when cleared; benches rebuild the
    // golden beat sequence from it.
    localparam logic [127:0] LFSR_SEED = 128'h0123456789abcdeffedcba9876543210;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } chk_state_t;

endpackage

// File: rtl/ddr3_chk_accum.sv
// Stage 2 of the read-data checker: saturating error-beat counter, sticky
// per-bit error mask and capture of the first failing beat.
module ddr3_chk_accum
    import ddr3_chk_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int BEATS_W  = 16,
    parameter int ERRCNT_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                clear,
    input  logic                diff_v,
    input  logic [DW-1:0]       diff_q,
    input  logic [DW-1:0]       data_q,
    input  logic [BEATS_W-1:0]  idx_q,
    output logic                hit,
    output logic [ERRCNT_W-1:0] err_cnt,
    output logic [DW-1:0]       err_bits,
    output logic [BEATS_W-1:0]  first_err_beat,
    output logic [DW-1:0]       first_err_data
);

    localparam logic [ERRCNT_W-1:0] ONE_E = {{(ERRCNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERRCNT_W-1:0] MAX_E = {ERRCNT_W{1'b1}};

    logic first_seen;

    // A staged beat is a failure when any bit differs from the pattern.
    assign hit = diff_v && (diff_q != {DW{1'b0}});

    // Accumulate failures; cleared at the start of each run, held otherwise.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_cnt        <= {ERRCNT_W{1'b0}};
            err_bits       <= {DW{1'b0}};
            first_err_beat <= {BEATS_W{1'b0}};
            first_err_data <= {DW{1'b0}};
            first_seen     <= 1'b0;
        end else if (clear) begin
            err_cnt        <= {ERRCNT_W{1'b0}};
            err_bits       <= {DW{1'b0}};
            first_err_beat <= {BEATS_W{1'b0}};
            first_err_data <= {DW{1'b0}};
            first_seen     <= 1'b0;
        end else if (hit) begin
            if (err_cnt != MAX_E) begin
                err_cnt <= err_cnt + ONE_E;
            end
            err_bits <= err_bits | diff_q;
            if (!first_seen) begin
                first_err_beat <= idx_q;
                first_err_data <= data_q;
                first_seen     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_rd_data_checker.sv
// DDR3 read-data checker: compares each read beat with the external pattern
// generator output, steps the generator once per accepted beat and reports
// error statistics and pass/fail to the test controller.
module ddr3_rd_data_checker
    import ddr3_chk_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int BEATS_W  = 16,
    parameter int ERRCNT_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                abort,
    input  logic [BEATS_W-1:0]  num_beats,
    input  logic                rd_valid,
    input  logic [DW-1:0]       rd_data,
    input  logic [DW-1:0]       exp_data,
    output logic                lfsr_clear,
    output logic                lfsr_enable,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERRCNT_W-1:0] err_cnt,
    output logic [DW-1:0]       err_bits,
    output logic [BEATS_W-1:0]  first_err_beat,
    output logic [DW-1:0]       first_err_data,
    output logic [BEATS_W-1:0]  beat_cnt
);

    localparam logic [BEATS_W-1:0] ONE_B  = {{(BEATS_W-1){1'b0}}, 1'b1};
    localparam logic [BEATS_W-1:0] ZERO_B = {BEATS_W{1'b0}};

    chk_state_t         state;
    logic [BEATS_W-1:0] num_q;
    logic               accept;
    logic               last_beat;
    logic               hit;

    // Stage-1 registers
    logic               diff_v;
    logic [DW-1:0]      diff_q;
    logic [DW-1:0]      data_q;
    logic [BEATS_W-1:0] idx_q;

    // A beat is taken only in RUN and never in an abort cycle.
    assign accept    = (state == RUN) && rd_valid && !abort;
    assign last_beat = (beat_cnt == (num_q - ONE_B));

    // The generator steps on the same edge that accepts a beat, so these
    // stay combinational; both are forced low while reset is asserted.
    assign lfsr_enable = accept && resetn;
    assign lfsr_clear  = (state == SEED) && resetn;

    // Control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            num_q <= ZERO_B;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= SEED;
                        num_q <= num_beats;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                SEED: begin
                    if (num_q == ZERO_B) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept && last_beat) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // err_cnt is still missing the final beat, which is in
                    // stage 2 this cycle as hit.
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_cnt == {ERRCNT_W{1'b0}}) && !hit;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: register the per-beat difference and count accepted beats.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            diff_v   <= 1'b0;
            diff_q   <= {DW{1'b0}};
            data_q   <= {DW{1'b0}};
            idx_q    <= ZERO_B;
            beat_cnt <= ZERO_B;
        end else if (abort) begin
            diff_v <= 1'b0;
        end else if (state == SEED) begin
            diff_v   <= 1'b0;
            beat_cnt <= ZERO_B;
        end else if (accept) begin
            diff_v   <= 1'b1;
            diff_q   <= rd_data ^ exp_data;
            data_q   <= rd_data;
            idx_q    <= beat_cnt;
            beat_cnt <= beat_cnt + ONE_B;
        end else begin
            diff_v <= 1'b0;
        end
    end

    ddr3_chk_accum #(
        .DW       (DW),
        .BEATS_W  (BEATS_W),
        .ERRCNT_W (ERRCNT_W)
    ) u_accum (
        .clk            (clk),
        .resetn         (resetn),
        .clear          ((state == SEED) && !abort),
        .diff_v         (diff_v),
        .diff_q         (diff_q),
        .data_q         (data_q),
        .idx_q          (idx_q),
        .hit            (hit),
        .err_cnt        (err_cnt),
        .err_bits       (err_bits),
        .first_err_beat (first_err_beat),
        .first_err_data (first_err_data)
    );

endmodule

// File: tb/tb_ddr3_rd_data_checker.sv
// Directed bench for ddr3_rd_data_checker with a behavioural 128-bit
// pattern generator wired to lfsr_clear/lfsr_enable/exp_data.
module tb_ddr3_rd_data_checker;
    import ddr3_chk_pkg::*;

    localparam int DW = 128;
    localparam int BW = 16;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          resetn, start, abort, rd_valid;
    logic [BW-1:0] num_beats;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] exp_data = 128'h0;
    logic          lfsr_clear, lfsr_enable, busy, done, pass;
    logic [EW-1:0] err_cnt;
    logic [DW-1:0] err_bits, first_err_data;
    logic [BW-1:0] first_err_beat, beat_cnt;

    int total = 0;
    int bad   = 0;
    int en_cnt  = 0;
    int clr_cnt = 0;
    int en0, clr0;

    logic [DW-1:0] gold    [0:31];
    logic [DW-1:0] corrupt [0:31];
    logic          vpat    [0:31];
    logic [EW-1:0] ecnt_hist [0:31];

    always #5 clk = ~clk;

    ddr3_rd_data_checker #(.DW(DW), .BEATS_W(BW), .ERRCNT_W(EW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .num_beats(num_beats), .rd_valid(rd_valid), .rd_data(rd_data),
        .exp_data(exp_data), .lfsr_clear(lfsr_clear), .lfsr_enable(lfsr_enable),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .err_bits(err_bits), .first_err_beat(first_err_beat),
        .first_err_data(first_err_data), .beat_cnt(beat_cnt)
    );

    function automatic logic [127:0] lfsr_step(input logic [127:0] q);
        return {q[126:0], 1'b0} ^ (q[127] ? 128'h87 : 128'h0);
    endfunction

    // Behavioural pattern generator plus cycle counters for clear/enable.
    always @(posedge clk) begin
        if (lfsr_clear)       exp_data <= LFSR_SEED;
        else if (lfsr_enable) exp_data <= lfsr_step(exp_data);
        if (lfsr_clear)  clr_cnt <= clr_cnt + 1;
        if (lfsr_enable) en_cnt  <= en_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic prep();
        for (int i = 0; i < 32; i++) begin
            corrupt[i] = 128'h0;
            vpat[i]    = 1'b1;
        end
    endtask

    // Pulse start; returns at the negedge inside the SEED cycle.
    task automatic launch(input int n);
        num_beats = n[BW-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drive ncyc cycles following vpat; records err_cnt one cycle after each beat.
    task automatic feed(input int ncyc);
        int k = 0;
        for (int c = 0; c < ncyc; c++) begin
            rd_valid = vpat[c];
            rd_data  = vpat[c] ? (gold[k] ^ corrupt[k]) : {DW{1'b1}};
            @(negedge clk);
            if (vpat[c]) begin
                ecnt_hist[k] = err_cnt;
                k++;
            end
        end
        rd_valid = 1'b0;
        rd_data  = 128'h0;
    endtask

    // Full run: start, SEED, beats, then FLUSH and DONE timing checks.
    task automatic do_run(input string tag, input int n, input int ncyc);
        en0  = en_cnt;
        clr0 = clr_cnt;
        launch(n);
        rd_valid = 1'b0;
        @(negedge clk);
        feed(ncyc);
        chk({tag, "_flush_done"}, done, 128'h0);
        @(negedge clk);
        chk({tag, "_done"}, done, 128'h1);
        chk({tag, "_busy"}, busy, 128'h0);
    endtask

    initial begin
        gold[0] = LFSR_SEED;
        for (int i = 1; i < 32; i++) gold[i] = lfsr_step(gold[i-1]);

        // Reset
        resetn = 1'b0; start = 1'b0; abort = 1'b0; rd_valid = 1'b1;
        num_beats = 16'd0; rd_data = 128'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 128'h0);
        chk("rst_done", done, 128'h0);
        chk("rst_pass", pass, 128'h0);
        chk("rst_errcnt", err_cnt, 128'h0);
        chk("rst_errbits", err_bits, 128'h0);
        chk("rst_beatcnt", beat_cnt, 128'h0);
        chk("rst_clear", lfsr_clear, 128'h0);
        chk("rst_enable", lfsr_enable, 128'h0);
        resetn = 1'b1; rd_valid = 1'b0;
        @(negedge clk);

        // Clean run of 4 back-to-back beats
        prep();
        do_run("clean", 4, 4);
        chk("clean_pass", pass, 128'h1);
        chk("clean_errcnt", err_cnt, 128'h0);
        chk("clean_errbits", err_bits, 128'h0);
        chk("clean_beatcnt", beat_cnt, 128'd4);
        chk("clean_en_cycles", en_cnt - en0, 128'd4);
        chk("clean_clr_cycles", clr_cnt - clr0, 128'd1);

        // Single-bit error on beat 2
        prep();
        corrupt[2] = 128'h20;
        do_run("bit5", 8, 8);
        chk("bit5_lat_before", ecnt_hist[2], 128'h0);
        chk("bit5_lat_after", ecnt_hist[3], 128'h1);
        chk("bit5_errcnt", err_cnt, 128'h1);
        chk("bit5_errbits", err_bits, 128'h20);
        chk("bit5_first_beat", first_err_beat, 128'd2);
        chk("bit5_first_data", first_err_data, gold[2] ^ 128'h20);
        chk("bit5_pass", pass, 128'h0);

        // Gapped valid pattern 1,0,0,1,1,0,1,1,1
        prep();
        vpat[1] = 1'b0; vpat[2] = 1'b0; vpat[5] = 1'b0;
        do_run("gap", 6, 9);
        chk("gap_pass", pass, 128'h1);
        chk("gap_errcnt", err_cnt, 128'h0);
        chk("gap_en_cycles", en_cnt - en0, 128'd6);
        chk("gap_beatcnt", beat_cnt, 128'd6);

        // Saturation: 20 corrupted beats into a 4-bit counter
        prep();
        for (int i = 0; i < 20; i++) corrupt[i] = 128'hff;
        do_run("sat", 20, 20);
        chk("sat_errcnt", err_cnt, 128'hf);
        chk("sat_first_beat", first_err_beat, 128'd0);
        chk("sat_first_data", first_err_data, gold[0] ^ 128'hff);
        chk("sat_errbits", err_bits, 128'hff);
        chk("sat_pass", pass, 128'h0);

        // Zero-length run straight after a failing run
        en0 = en_cnt;
        launch(0);
        rd_valid = 1'b1; rd_data = gold[0];
        #1;
        chk("zero_seed_clear", lfsr_clear, 128'h1);
        chk("zero_seed_busy", busy, 128'h1);
        chk("zero_seed_enable", lfsr_enable, 128'h0);
        @(negedge clk);
        chk("zero_done", done, 128'h1);
        chk("zero_pass", pass, 128'h1);
        chk("zero_errcnt", err_cnt, 128'h0);
        chk("zero_done_enable", lfsr_enable, 128'h0);
        rd_valid = 1'b0;
        @(negedge clk);
        chk("zero_en_cycles", en_cnt - en0, 128'd0);

        // Abort after 3 of 10 beats; start during RUN and alongside abort is ignored
        prep();
        corrupt[1] = 128'h4;
        launch(10);
        rd_valid = 1'b0;
        @(negedge clk);
        rd_valid = 1'b1; rd_data = gold[0]; start = 1'b1; num_beats = 16'd2;
        @(negedge clk);
        start = 1'b0;
        rd_data = gold[1] ^ 128'h4;
        @(negedge clk);
        rd_data = gold[2];
        @(negedge clk);
        abort = 1'b1; start = 1'b1; num_beats = 16'd5; rd_data = gold[3];
        #1;
        chk("abort_enable", lfsr_enable, 128'h0);
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_busy", busy, 128'h0);
        chk("abort_done", done, 128'h0);
        chk("abort_clear", lfsr_clear, 128'h0);
        chk("abort_beatcnt", beat_cnt, 128'd3);
        chk("abort_errcnt", err_cnt, 128'h1);
        chk("abort_first_beat", first_err_beat, 128'd1);
        chk("abort_first_data", first_err_data, gold[1] ^ 128'h4);
        chk("abort_idle_enable", lfsr_enable, 128'h0);
        rd_valid = 1'b0;
        @(negedge clk);
        prep();
        do_run("restart", 2, 2);
        chk("restart_clr_cycles", clr_cnt - clr0, 128'd1);
        chk("restart_pass", pass, 128'h1);
        chk("restart_errcnt", err_cnt, 128'h0);

        // Synchronous reset in the middle of a run
        prep();
        corrupt[0] = 128'h1;
        launch(10);
        rd_valid = 1'b0;
        @(negedge clk);
        feed(3);
        chk("midrst_pre_errcnt", err_cnt, 128'h1);
        resetn = 1'b0; rd_valid = 1'b1; rd_data = gold[3];
        #1;
        chk("midrst_enable", lfsr_enable, 128'h0);
        @(negedge clk);
        chk("midrst_busy", busy, 128'h0);
        chk("midrst_done", done, 128'h0);
        chk("midrst_errcnt", err_cnt, 128'h0);
        chk("midrst_errbits", err_bits, 128'h0);
        chk("midrst_beatcnt", beat_cnt, 128'h0);
        chk("midrst_first_data", first_err_data, 128'h0);
        chk("midrst_clear", lfsr_clear, 128'h0);
        resetn = 1'b1; rd_valid = 1'b0;
        @(negedge clk);
        chk("midrst_idle_busy", busy, 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
